sdram_test_console: RTL and testbench

//  Parametrised board-level test console for the SDRAM controller: debounces separate write/read

---
 rtl/sdram_test_console_pkg.sv | 24 ++
 rtl/sdram_test_console_button_debounce.sv | 50 +++++
 rtl/sdram_test_console.sv | 171 +++++++++++++++++
 tb/tb_sdram_test_console.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_test_console_pkg.sv
// Shared encodings for the SDRAM test console: access FSM states and pending operation codes.
package sdram_test_console_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_WR   = 2'd1,
    OP_RD   = 2'd2
  } op_t;

  // Write has priority when both buttons fire in the same cycle.
  function automatic op_t pick_op(input logic wr_evt, input logic rd_evt, input op_t cur);
    if (wr_evt)      return OP_WR;
    else if (rd_evt) return OP_RD;
    else             return cur;
  endfunction

endpackage

// File: rtl/sdram_test_console_button_debounce.sv
// Two-flop synchroniser plus counter debounce for an active-low push button.
// o_level is the debounced pressed level; o_press pulses one cycle on each new press.
module button_debounce #(
  parameter int DEBOUNCE_WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_level,
  output logic o_press
);

  logic                      r_sync1;
  logic                      r_sync2;
  logic                      r_level;
  logic                      r_press;
  logic [DEBOUNCE_WIDTH-1:0] r_cnt;
  logic                      w_pressed;

  assign w_pressed = ~r_sync2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (w_pressed == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == '1) begin
        // 2**DEBOUNCE_WIDTH consecutive disagreeing cycles: accept the new level.
        r_cnt   <= '0;
        r_level <= w_pressed;
        r_press <= w_pressed;
      end else begin
        r_cnt <= r_cnt + DEBOUNCE_WIDTH'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/sdram_test_console.sv
// Board test console for the SDRAM controller host port: button-driven single reads/writes,
// DIP-derived write data, captured read data paged across the LEDs, sticky ack-timeout flag.
module sdram_test_console
  import sdram_test_console_pkg::*;
#(
  parameter int HADDR_WIDTH    = 24,
  parameter int DATA_WIDTH     = 16,
  parameter int DIP_WIDTH      = 4,
  parameter int LED_WIDTH      = 8,
  parameter int DEBOUNCE_WIDTH = 16,
  parameter int LED_BLINK      = 27,
  parameter int TIMEOUT_WIDTH  = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   btn_wr_n,
  input  logic                   btn_rd_n,
  input  logic [DIP_WIDTH-1:0]   dip,
  input  logic                   auto_inc,
  output logic [LED_WIDTH-1:0]   leds,
  output logic                   err,
  output logic [HADDR_WIDTH-1:0] haddr,
  output logic [DATA_WIDTH-1:0]  data_input,
  input  logic [DATA_WIDTH-1:0]  data_output,
  input  logic                   busy,
  output logic                   rd_enable,
  output logic                   wr_enable
);

  localparam int CHUNKS = DATA_WIDTH / DIP_WIDTH;
  localparam int PAGES  = DATA_WIDTH / LED_WIDTH;
  localparam int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1;
  // The ISSUE cycle counts as the first unacknowledged cycle, so the last one is 2**W-2.
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = TIMEOUT_WIDTH'((2 ** TIMEOUT_WIDTH) - 2);

  state_t                   r_state;
  state_t                   w_next_state;
  op_t                      r_op;
  logic [HADDR_WIDTH-1:0]   r_haddr;
  logic [HADDR_WIDTH-1:0]   w_seed;
  logic [DATA_WIDTH-1:0]    r_captured;
  logic [TIMEOUT_WIDTH-1:0] r_to_cnt;
  logic                     r_err;
  logic [LED_BLINK-1:0]     r_led_cnt;
  logic [PAGE_W-1:0]        r_page;
  logic [LED_WIDTH-1:0]     w_pages [PAGES];

  logic w_wr_level;
  logic w_wr_press;
  logic w_rd_level;
  logic w_rd_press;
  logic w_wr_evt;
  logic w_rd_evt;
  logic w_timeout;
  logic w_done;

  button_debounce #(.DEBOUNCE_WIDTH(DEBOUNCE_WIDTH)) u_wr_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn_n (btn_wr_n),
    .o_level (w_wr_level),
    .o_press (w_wr_press)
  );

  button_debounce #(.DEBOUNCE_WIDTH(DEBOUNCE_WIDTH)) u_rd_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn_n (btn_rd_n),
    .o_level (w_rd_level),
    .o_press (w_rd_press)
  );

  assign w_wr_evt = w_wr_press & w_wr_level;
  assign w_rd_evt = w_rd_press & w_rd_level;

  for (genvar i = 0; i < HADDR_WIDTH; i++) begin : g_seed
    assign w_seed[i] = dip[i % DIP_WIDTH];
  end

  // Lower half of the word carries the inverted switches, upper half the switches as set.
  for (genvar k = 0; k < CHUNKS; k++) begin : g_wdata
    assign data_input[k*DIP_WIDTH +: DIP_WIDTH] = (k < CHUNKS / 2) ? ~dip : dip;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_timeout    = 1'b0;
    w_done       = 1'b0;
    wr_enable    = 1'b0;
    rd_enable    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((r_op != OP_NONE) && !busy) w_next_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        wr_enable    = (r_op == OP_WR);
        rd_enable    = (r_op == OP_RD);
        w_next_state = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (busy) begin
          w_next_state = ST_WAIT_DONE;
        end else if (r_to_cnt == TO_LAST) begin
          w_timeout    = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!busy) begin
          w_done       = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op       <= OP_NONE;
      r_haddr    <= w_seed;
      r_err      <= 1'b0;
      r_captured <= '0;
      r_to_cnt   <= '0;
    end else begin
      // Presses only register while idle; anything arriving mid-access is dropped.
      if (r_state == ST_IDLE) begin
        r_to_cnt <= '0;
        r_op     <= pick_op(w_wr_evt, w_rd_evt, r_op);
      end else begin
        r_to_cnt <= r_to_cnt + TIMEOUT_WIDTH'(1);
      end
      if (w_timeout) begin
        r_err <= 1'b1;
        r_op  <= OP_NONE;
      end
      if (w_done) begin
        if (r_op == OP_RD) r_captured <= data_output;
        if (auto_inc)      r_haddr    <= r_haddr + HADDR_WIDTH'(1);
        r_op <= OP_NONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_led_cnt <= '0;
      r_page    <= '0;
    end else begin
      r_led_cnt <= r_led_cnt + LED_BLINK'(1);
      if (r_led_cnt == '1) begin
        r_page <= (r_page == PAGE_W'(PAGES - 1)) ? '0 : r_page + PAGE_W'(1);
      end
    end
  end

  for (genvar p = 0; p < PAGES; p++) begin : g_pages
    assign w_pages[p] = r_captured[p*LED_WIDTH +: LED_WIDTH];
  end

  assign leds  = w_pages[r_page];
  assign err   = r_err;
  assign haddr = r_haddr;

endmodule

// File: tb/tb_sdram_test_console.sv
// Directed bench for sdram_test_console: reset vector table plus hand-written access sequences
// against a small busy/ack controller model.
module tb_sdram_test_console;

  localparam int HW = 8;
  localparam int DW = 16;
  localparam int PW = 4;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          btn_wr_n;
  logic          btn_rd_n;
  logic [PW-1:0] dip;
  logic          auto_inc;
  logic [LW-1:0] leds;
  logic          err;
  logic [HW-1:0] haddr;
  logic [DW-1:0] data_input;
  logic [DW-1:0] data_output = '0;
  logic          busy = 1'b0;
  logic          rd_enable;
  logic          wr_enable;

  int n_checks  = 0;
  int n_fail    = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;

  bit            ack_en       = 1'b1;
  logic [DW-1:0] rd_data_model = '0;
  int            busy_left    = 0;
  bit            ack_pend     = 1'b0;

  always #5 clk = ~clk;

  sdram_test_console #(
    .HADDR_WIDTH    (HW),
    .DATA_WIDTH     (DW),
    .DIP_WIDTH      (PW),
    .LED_WIDTH      (LW),
    .DEBOUNCE_WIDTH (2),
    .LED_BLINK      (4),
    .TIMEOUT_WIDTH  (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_wr_n    (btn_wr_n),
    .btn_rd_n    (btn_rd_n),
    .dip         (dip),
    .auto_inc    (auto_inc),
    .leds        (leds),
    .err         (err),
    .haddr       (haddr),
    .data_input  (data_input),
    .data_output (data_output),
    .busy        (busy),
    .rd_enable   (rd_enable),
    .wr_enable   (wr_enable)
  );

  // Controller model: busy rises one cycle after a request and stays high for 5 cycles.
  always @(negedge clk) begin
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) busy = 1'b0;
    end
    if (ack_pend) begin
      ack_pend  = 1'b0;
      busy      = 1'b1;
      busy_left = 5;
    end
    if (ack_en && (wr_enable === 1'b1 || rd_enable === 1'b1)) begin
      ack_pend    = 1'b1;
      data_output = rd_data_model;
    end
  end

  always @(posedge clk) begin
    if (wr_enable === 1'b1) wr_pulses++;
    if (rd_enable === 1'b1) rd_pulses++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_req(input bit is_wr, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((is_wr ? wr_enable : rd_enable) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  typedef struct {
    logic [PW-1:0] dip;
    logic [HW-1:0] haddr;
    logic [DW-1:0] data;
  } rst_vec_t;

  rst_vec_t vecs [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int k;
    int m;

    vecs[0] = '{dip: 4'h0, haddr: 8'h00, data: 16'h00FF};
    vecs[1] = '{dip: 4'h5, haddr: 8'h55, data: 16'h55AA};
    vecs[2] = '{dip: 4'h3, haddr: 8'h33, data: 16'h33CC};
    vecs[3] = '{dip: 4'hF, haddr: 8'hFF, data: 16'hFF00};
    vecs[4] = '{dip: 4'hA, haddr: 8'hAA, data: 16'hAA55};

    rst_n    = 1'b0;
    btn_wr_n = 1'b1;
    btn_rd_n = 1'b1;
    dip      = 4'hA;
    auto_inc = 1'b1;
    tick(1);

    for (int i = 0; i < 5; i++) begin
      dip   = vecs[i].dip;
      rst_n = 1'b0;
      tick(2);
      check("rst_haddr", haddr, vecs[i].haddr);
      check("rst_wdata", data_input, vecs[i].data);
      check("rst_leds", leds, 8'h00);
      check("rst_err", err, 1'b0);
      check("rst_req", {wr_enable, rd_enable}, 2'b00);
    end

    rst_n = 1'b1;
    tick(10);
    check("idle_wr_pulses", wr_pulses, 0);
    check("idle_rd_pulses", rd_pulses, 0);

    // Held write press: one write, address advances.
    btn_wr_n = 1'b0;
    tick(8);
    btn_wr_n = 1'b1;
    tick(20);
    check("wr_pulses", wr_pulses, 1);
    check("wr_no_rd", rd_pulses, 0);
    check("wr_haddr_inc", haddr, 8'hAB);
    check("wr_err", err, 1'b0);

    // Two-cycle glitch must not reach the FSM.
    btn_wr_n = 1'b0;
    tick(2);
    btn_wr_n = 1'b1;
    tick(20);
    check("glitch_wr_pulses", wr_pulses, 1);
    check("glitch_haddr", haddr, 8'hAB);

    // Read capture and LED paging.
    rd_data_model = 16'h12C3;
    btn_rd_n = 1'b0;
    tick(8);
    btn_rd_n = 1'b1;
    tick(20);
    check("rd_pulses", rd_pulses, 1);
    check("rd_haddr_inc", haddr, 8'hAC);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (leds == 8'hC3) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check("led_low_page_seen", ok, 1'b1);
    k = 0;
    while (leds == 8'hC3 && k < 20) begin
      tick(1);
      k++;
    end
    check("led_high_page", leds, 8'h12);
    check("led_low_page_len_ok", (k >= 1 && k <= 16), 1'b1);
    m = 0;
    while (leds == 8'h12 && m < 20) begin
      tick(1);
      m++;
    end
    check("led_high_page_len", m, 16);
    check("led_wrap_to_low", leds, 8'hC3);

    // Both buttons in the same cycle: write wins.
    btn_wr_n = 1'b0;
    btn_rd_n = 1'b0;
    tick(8);
    btn_wr_n = 1'b1;
    btn_rd_n = 1'b1;
    tick(20);
    check("both_wr_pulses", wr_pulses, 2);
    check("both_rd_dropped", rd_pulses, 1);
    check("both_haddr", haddr, 8'hAD);

    // Read press debounced while the write sits in WAIT_DONE is dropped.
    btn_wr_n = 1'b0;
    tick(6);
    btn_rd_n = 1'b0;
    tick(2);
    btn_wr_n = 1'b1;
    tick(6);
    btn_rd_n = 1'b1;
    tick(20);
    check("busy_press_wr", wr_pulses, 3);
    check("busy_press_rd_ignored", rd_pulses, 1);
    check("busy_press_haddr", haddr, 8'hAE);

    // Controller never acknowledges.
    ack_en   = 1'b0;
    btn_wr_n = 1'b0;
    wait_req(1'b1, 20, ok);
    check("to_wr_seen", ok, 1'b1);
    btn_wr_n = 1'b1;
    tick(6);
    check("to_err_before", err, 1'b0);
    tick(1);
    check("to_err_set", err, 1'b1);
    check("to_haddr_kept", haddr, 8'hAE);
    tick(10);
    check("to_single_pulse", wr_pulses, 4);

    ack_en   = 1'b1;
    btn_wr_n = 1'b0;
    tick(8);
    btn_wr_n = 1'b1;
    tick(20);
    check("after_to_wr", wr_pulses, 5);
    check("after_to_haddr", haddr, 8'hAF);
    check("err_sticky", err, 1'b1);

    // Address wrap on a completed read.
    rst_n = 1'b0;
    dip   = 4'hF;
    tick(2);
    check("wrap_rst_haddr", haddr, 8'hFF);
    check("wrap_rst_err", err, 1'b0);
    rst_n = 1'b1;
    tick(2);
    rd_data_model = 16'hBEEF;
    btn_rd_n = 1'b0;
    tick(8);
    btn_rd_n = 1'b1;
    tick(20);
    check("wrap_rd_pulses", rd_pulses, 2);
    check("wrap_haddr", haddr, 8'h00);
    check("wrap_leds", (leds == 8'hEF || leds == 8'hBE), 1'b1);

    // Reset during WAIT_DONE abandons the read.
    rd_data_model = 16'h5A5A;
    btn_rd_n = 1'b0;
    wait_req(1'b0, 20, ok);
    check("abort_rd_seen", ok, 1'b1);
    btn_rd_n = 1'b1;
    tick(3);
    rst_n = 1'b0;
    dip   = 4'h3;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    check("abort_leds", leds, 8'h00);
    check("abort_no_reissue", rd_pulses, 3);
    check("abort_haddr", haddr, 8'h33);
    check("abort_err", err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
